// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Central reset generator for the always-on clock domain. Collects software,
//   watchdog and external reset requests, holds every downstream domain reset
//   asserted for at least ASSERT_CYCLES edges, then releases the domains one at
//   a time in index order, STAGGER_CYCLES edges apart.
//
//   Every output comes straight from a flop. The outputs drive asynchronous
//   reset pins downstream, so they must never glitch.
//
//   Optional feature macro: RESET_SEQ_CAUSE_EN
//     defined   - reset_cause holds sticky {ext, wdt, sw} request bits, which
//                 cause_clear clears.
//     undefined - reset_cause is tied to 3'b000, cause_clear is ignored and no
//                 cause flops exist.

module reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int ASSERT_CYCLES  = 16,
  parameter int STAGGER_CYCLES = 8
) (
  input  logic                   clock_domain,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic                   wdt_reset_req,
  input  logic                   ext_reset_req,
  input  logic                   cause_clear,
  output logic [NUM_DOMAINS-1:0] domain_reset_n_out,
  output logic                   sequence_busy,
  output logic                   sequence_done,
  output logic [2:0]             reset_cause
);

  // ---------------------------------------------------------------------------
  // Parameter limits, checked at elaboration
  // ---------------------------------------------------------------------------
  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_num_domains
    $error("reset_sequencer: NUM_DOMAINS must be in 1..8");
  end
  if (ASSERT_CYCLES < 2) begin : g_bad_assert_cycles
    $error("reset_sequencer: ASSERT_CYCLES must be >= 2");
  end
  if (STAGGER_CYCLES < 1) begin : g_bad_stagger_cycles
    $error("reset_sequencer: STAGGER_CYCLES must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Local sizing
  // ---------------------------------------------------------------------------
  // The counter counts up from 0 and is reloaded on every phase entry, so it
  // only has to reach the larger of the two phase lengths.
  localparam int MAX_CYCLES = (ASSERT_CYCLES > STAGGER_CYCLES) ? ASSERT_CYCLES
                                                              : STAGGER_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  // Counter value seen on the edge that ends a phase.
  localparam logic [CNT_W-1:0] ASSERT_LAST  = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_DOMAINS - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;        // next domain to release
  logic [NUM_DOMAINS-1:0] r_rst_n;
  logic                   r_busy;
  logic                   r_done;

  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [NUM_DOMAINS-1:0] w_rst_n_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;

  logic                   w_any_req;
  logic [2:0]             w_req_vec;

  assign w_req_vec = {ext_reset_req, wdt_reset_req, sw_reset_req};
  assign w_any_req = |w_req_vec;

  // State register and output flops; reset sampled synchronously.
  always_ff @(posedge clock_domain) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before this edge and evaluation order cannot matter.
    if (reset) begin
      r_state <= ST_ASSERT;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: a request overrides everything, otherwise walk the phases.
  always_comb begin
    // NOTE: every signal gets a default before any branch. A path that left one
    // unassigned would infer a latch.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_n_nxt = r_rst_n;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    if (w_any_req) begin
      // Any request asserts every domain on the sampling edge. In ASSERT this
      // reloads the count, which extends the hold. In RELEASE it aborts.
      w_state_nxt = ST_ASSERT;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
      w_rst_n_nxt = '0;
      w_busy_nxt  = 1'b1;
    end else begin
      unique case (r_state)
        ST_ASSERT: begin
          w_rst_n_nxt = '0;
          w_busy_nxt  = 1'b1;
          if (r_cnt == ASSERT_LAST) begin
            w_rst_n_nxt[0] = 1'b1;
            w_cnt_nxt      = '0;
            if (NUM_DOMAINS == 1) begin
              // The first release is also the last one.
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_idx_nxt   = IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (r_cnt == STAGGER_LAST) begin
            // Only ever set bits here, so released bits stay high.
            w_rst_n_nxt[r_idx] = 1'b1;
            w_cnt_nxt          = '0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end

        ST_IDLE: begin
          w_rst_n_nxt = '1;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end

        default: begin
          // Recover from an illegal encoding by restarting a full sequence.
          w_state_nxt = ST_ASSERT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_n_nxt = '0;
          w_busy_nxt  = 1'b1;
        end
      endcase
    end
  end

  assign domain_reset_n_out = r_rst_n;
  assign sequence_busy      = r_busy;
  assign sequence_done      = r_done;

  // ---------------------------------------------------------------------------
  // Sticky reset cause
  // ---------------------------------------------------------------------------
`ifdef RESET_SEQ_CAUSE_EN
  logic [2:0] r_cause;

  // Capture request sources even while reset is high. A new request beats a
  // clear on the same edge, and reset clears only when no request is present.
  always_ff @(posedge clock_domain) begin
    if (reset && !w_any_req) begin
      r_cause <= 3'b000;
    end else if (cause_clear) begin
      r_cause <= w_req_vec;
    end else begin
      r_cause <= r_cause | w_req_vec;
    end
  end

  assign reset_cause = r_cause;
`else
  logic w_unused_cause_clear;

  assign w_unused_cause_clear = cause_clear;
  assign reset_cause          = 3'b000;
`endif

endmodule
